fft_csi_capture: RTL and testbench
==================================

# fft_csi_capture

Consumer-side block for the 64-point pipelined FFT. It takes the FFT's natural-order output stream (`i_ce`/`i_sync`/`i_result`) and captures each 64-bin frame into a ping-pong buffer. It then replays only the used OFDM subcarriers, in fftshift order (−NUSED..−1, +1..+NUSED), on an AXI-Stream master toward the CSI DMA path. The FFT is never stalled; frames arriving while both buffers are full are dropped and counted.

## Interface

- WIDTH, 16: bits per real/imag component; sample is 2*WIDTH (real high, imag low)
- LGSIZE, 6: log2 FFT size N (N=64)
- NUSED, 26: used subcarriers per side; frame output length 2*NUSED (52); 1 ≤ NUSED ≤ N/2−1
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_ce  in  1  FFT output qualifier; `i_result`/`i_sync` valid only when high
- i_sync  in  1  high with bin 0 of each FFT frame (qualified by `i_ce`)
- i_result  in  2*WIDTH  FFT bin value, natural order 0..N−1
- m_axis_tvalid  out  1  output sample valid
- m_axis_tready  in  1  downstream ready
- m_axis_tdata  out  2*WIDTH  subcarrier value, same packing as `i_result`
- m_axis_tuser  out  1  high on first subcarrier (bin N−NUSED) of frame
- m_axis_tlast  out  1  high on last subcarrier (bin NUSED) of frame
- o_drop_count  out  16  frames dropped for lack of buffer, saturates at 0xFFFF
- o_resync  out  1  one-cycle pulse: `i_sync` seen mid-frame, partial frame discarded

## Operation

- Storage: two N-entry banks (2*N words, inferred RAM, 1-cycle read latency), with per-bank state EMPTY / FILLING / FULL.
- Write FSM states: WAIT_SYNC, CAPTURE, SKIP.
  - WAIT_SYNC: on `i_ce && i_sync`:
    - If bank `wr_bank` is EMPTY: write bin 0, set that bank FILLING, set index=1, go to CAPTURE.
    - Otherwise: increment `o_drop_count` (saturating), set index=1, go to SKIP.
  - CAPTURE: on each `i_ce`, write `i_result` at the index, then increment the index.
    - On the write of index N−1: bank becomes FULL, `wr_bank` toggles, go to WAIT_SYNC.
  - SKIP: count `i_ce` without writing; return to WAIT_SYNC after index N−1.
  - `i_sync` with index≠0 in CAPTURE or SKIP:
    - Pulse `o_resync`.
    - A FILLING bank reverts to EMPTY.
    - The new sync is then handled exactly as in WAIT_SYNC in the same cycle.
- Banks complete strictly alternately; readout therefore also alternates, starting with bank 0 after reset.
- Read FSM states: IDLE, STREAM.
  - IDLE: when `rd_bank` is FULL, go to STREAM.
  - STREAM: read address sequence is N−NUSED..N−1, then 1..NUSED. Bin 0 (DC) and bins NUSED+1..N−NUSED−1 are never output.
  - Output stage is a 2-entry skid buffer behind the RAM. Reads are issued only when the skid buffer has space, so no sample is lost or duplicated under arbitrary `tready`.
  - When the `tlast` beat is accepted (`tvalid && tready`): `rd_bank` returns to EMPTY, `rd_bank` toggles, go to IDLE.
- `tdata`, `tuser` and `tlast` stay stable while `tvalid && !tready`.
- Same-cycle events:
  - Read release of one bank and write completion of the other both take effect.
  - Release of a bank and a sync targeting that bank: the writer sees the bank as EMPTY, so the frame is captured, not dropped.

## Timing

- Reset values:
  - `m_axis_tvalid`, `tuser`, `tlast` = 0.
  - `o_drop_count` = 0.
  - `o_resync` = 0.
  - Both banks EMPTY, `wr_bank`=`rd_bank`=0, FSMs in WAIT_SYNC/IDLE.
  - `tdata` is don't-care.
- Reset mid-frame or mid-stream discards all buffered data immediately. No partial frame is emitted after reset.
- Latency: the `i_ce` cycle writing bin N−1 is cycle 0. `m_axis_tvalid` rises at cycle 3 with bin N−NUSED and `tuser`=1.
- With `tready` held high, one beat is output per clock: 2*NUSED consecutive beats.
- The next FULL bank starts streaming with at most 2 idle cycles after the previous `tlast` beat.
- `i_ce` may have arbitrary gaps. With a continuous `i_ce` and `tready` high, no frames drop as long as 2*NUSED+4 ≤ N.
- `o_resync` is registered and asserts the cycle after the offending `i_sync`.

## Test plan

- Single frame: reset, then 64 continuous `i_ce` with bin k = {k, −k} and `tready`=1.
  - Required: 52 beats: 38..63 then 1..26.
  - `tuser` high on bin 38 only, `tlast` high on bin 26 only.
  - First beat 3 cycles after bin 63.
- Back-to-back frames: 10 continuous frames with a distinct tag per frame and `tready`=1.
  - Required: 520 beats in frame order, `o_drop_count`=0.
- Backpressure: random 30% `tready` over 4 frames with `i_ce` continuous.
  - Required: every accepted beat matches the model, `tdata` stable while stalled.
  - `o_drop_count` equals the model's count of frames arriving with both banks FULL.
- Overflow: `tready`=0 for 3 frames, then `tready`=1.
  - Required: `o_drop_count`=1; frames 1 and 2 are output intact, frame 3 never appears.
- Resync: `i_sync` at index 20 of a capture.
  - Required: `o_resync` pulses once; the partial frame is never output; the frame starting at the new sync is output correctly.
- Reset mid-stream: assert `i_reset` at output beat 10.
  - Required: `tvalid`=0 the cycle after reset; the next full frame is output from `tuser` with counters at 0.

Source files
------------

// File: rtl/fft_csi_capture_if.sv
// AXI-Stream link carrying captured CSI subcarriers toward the DMA path.
// Sample packing: real component in the upper WIDTH bits, imaginary in the lower.
interface fft_csi_capture_if #(
  parameter int WIDTH = 16
);
  logic               tvalid;
  logic               tready;
  logic [2*WIDTH-1:0] tdata;
  logic               tuser;
  logic               tlast;

  modport master (output tvalid, tdata, tuser, tlast, input tready);
  modport slave  (input tvalid, tdata, tuser, tlast, output tready);
endinterface

// File: rtl/fft_csi_capture.sv
// Captures 64-bin FFT frames into a ping-pong RAM and replays the used OFDM
// subcarriers in fftshift order (-NUSED..-1, +1..+NUSED) on an AXI-Stream
// master. The FFT side is never stalled; a frame is dropped and counted when
// the bank it would land in is still waiting to be read out.
module fft_csi_capture #(
  parameter int WIDTH  = 16,
  parameter int LGSIZE = 6,
  parameter int NUSED  = 26
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_ce,
  input  logic                 i_sync,
  input  logic [2*WIDTH-1:0]   i_result,
  fft_csi_capture_if.master    m_axis,
  output logic [15:0]          o_drop_count,
  output logic                 o_resync
);

  localparam int N    = 1 << LGSIZE;
  localparam int NOUT = 2 * NUSED;
  localparam int CW   = $clog2(NOUT + 1);
  localparam int DW   = 2 * WIDTH;
  localparam logic [LGSIZE-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {BANK_EMPTY, BANK_FILLING, BANK_FULL} bank_state_e;
  typedef enum logic [1:0] {WAIT_SYNC, CAPTURE, SKIP} wr_state_e;
  typedef enum logic {IDLE, STREAM} rd_state_e;

  typedef struct packed {
    logic          user;
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  // Storage and bank bookkeeping
  logic [DW-1:0] mem [2*N];
  bank_state_e   bank_q [2];

  // Write side
  wr_state_e         wr_state_q, wr_state_d;
  logic [LGSIZE-1:0] wr_idx_q, wr_idx_d;
  logic [LGSIZE-1:0] wr_addr;
  logic              wr_bank_q, wr_bank_d;
  logic              wr_bank_free;
  logic              mem_we;
  logic              set_filling, set_full;
  logic              drop_inc;
  logic              resync_d;
  logic [15:0]       drop_q;
  logic              resync_q;

  // Read side
  rd_state_e         rd_state_q, rd_state_d;
  logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
  logic [LGSIZE-1:0] rd_addr;
  logic              rd_bank_q, rd_bank_d;
  logic              rd_issue;
  logic              rd_release;
  logic [DW-1:0]     rd_data_q;
  logic              rd_pend_q, rd_pend_user_q, rd_pend_last_q;

  // Two-entry skid buffer, q0 is the head presented on the bus
  beat_t             q0, q1;
  beat_t             push_beat;
  logic [1:0]        fifo_cnt_q;
  logic [1:0]        occ_next;
  logic              push, pop, space;

  // A bank released by the reader this cycle is already free for the writer.
  assign wr_bank_free = (bank_q[wr_bank_q] == BANK_EMPTY) ||
                        (rd_release && (rd_bank_q == wr_bank_q));

  // Write FSM state register and frame bookkeeping
  always_ff @(posedge i_clk) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (i_reset) begin
      wr_state_q <= WAIT_SYNC;
      wr_idx_q   <= '0;
      wr_bank_q  <= 1'b0;
      drop_q     <= '0;
      resync_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_idx_q   <= wr_idx_d;
      wr_bank_q  <= wr_bank_d;
      resync_q   <= resync_d;
      if (drop_inc && (drop_q != 16'hFFFF)) drop_q <= drop_q + 1'b1;
    end
  end

  // Write FSM next state: capture, skip or restart on each qualified sample
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value held (no latches).
    wr_state_d  = wr_state_q;
    wr_idx_d    = wr_idx_q;
    wr_bank_d   = wr_bank_q;
    wr_addr     = wr_idx_q;
    mem_we      = 1'b0;
    set_filling = 1'b0;
    set_full    = 1'b0;
    drop_inc    = 1'b0;
    resync_d    = 1'b0;
    if (i_ce && i_sync) begin
      // A sync mid-frame abandons the partial frame. When capturing, the
      // filling bank reverts to empty and is immediately refilled, so it
      // simply stays FILLING while bin 0 is rewritten.
      resync_d = (wr_state_q != WAIT_SYNC);
      wr_addr  = '0;
      wr_idx_d = LGSIZE'(1);
      if ((wr_state_q == CAPTURE) || wr_bank_free) begin
        mem_we      = 1'b1;
        set_filling = 1'b1;
        wr_state_d  = CAPTURE;
      end else begin
        drop_inc   = 1'b1;
        wr_state_d = SKIP;
      end
    end else if (i_ce) begin
      case (wr_state_q)
        CAPTURE: begin
          mem_we   = 1'b1;
          wr_idx_d = wr_idx_q + 1'b1;
          if (wr_idx_q == LAST_IDX) begin
            set_full   = 1'b1;
            wr_bank_d  = ~wr_bank_q;
            wr_state_d = WAIT_SYNC;
          end
        end
        SKIP: begin
          wr_idx_d = wr_idx_q + 1'b1;
          if (wr_idx_q == LAST_IDX) wr_state_d = WAIT_SYNC;
        end
        default: ;
      endcase
    end
  end

  // Frame RAM: one write port from the FFT, one registered read port
  always_ff @(posedge i_clk) begin
    // NOTE: the RAM array is deliberately not reset; bank state alone says what is valid.
    if (mem_we) mem[{wr_bank_q, wr_addr}] <= i_result;
    if (rd_issue) rd_data_q <= mem[{rd_bank_q, rd_addr}];
  end

  // Bank ownership: reader release and writer fill/complete may hit both banks at once
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bank_q[0] <= BANK_EMPTY;
      bank_q[1] <= BANK_EMPTY;
    end else begin
      if (rd_release)  bank_q[rd_bank_q] <= BANK_EMPTY;
      if (set_filling) bank_q[wr_bank_q] <= BANK_FILLING;
      if (set_full)    bank_q[wr_bank_q] <= BANK_FULL;
    end
  end

  // Read address: upper (negative) subcarriers first, then 1..NUSED, DC skipped
  always_comb begin
    if (rd_cnt_q < CW'(NUSED)) rd_addr = LGSIZE'(N - NUSED) + LGSIZE'(rd_cnt_q);
    else                       rd_addr = LGSIZE'(rd_cnt_q) - LGSIZE'(NUSED - 1);
  end

  // Skid-buffer flow control: a read is issued only if its data is sure to fit
  always_comb begin
    push      = rd_pend_q;
    pop       = (fifo_cnt_q != 2'd0) && m_axis.tready;
    occ_next  = fifo_cnt_q + {1'b0, rd_pend_q} - {1'b0, pop};
    space     = (occ_next < 2'd2);
    rd_release = pop && q0.last;
    push_beat = '{user: rd_pend_user_q, last: rd_pend_last_q, data: rd_data_q};
  end

  // Read FSM next state: start on a FULL bank, stream NOUT reads, release on tlast
  always_comb begin
    rd_state_d = rd_state_q;
    rd_bank_d  = rd_bank_q;
    rd_cnt_d   = rd_cnt_q;
    rd_issue   = 1'b0;
    case (rd_state_q)
      IDLE: begin
        if ((bank_q[rd_bank_q] == BANK_FULL) && space) begin
          rd_issue   = 1'b1;
          rd_cnt_d   = rd_cnt_q + 1'b1;
          rd_state_d = STREAM;
        end
      end
      STREAM: begin
        if ((rd_cnt_q != CW'(NOUT)) && space) begin
          rd_issue = 1'b1;
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
        if (rd_release) begin
          rd_state_d = IDLE;
          rd_bank_d  = ~rd_bank_q;
          rd_cnt_d   = '0;
        end
      end
      default: ;
    endcase
  end

  // Read FSM state register, RAM-latency tags and skid buffer contents
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rd_state_q     <= IDLE;
      rd_bank_q      <= 1'b0;
      rd_cnt_q       <= '0;
      rd_pend_q      <= 1'b0;
      rd_pend_user_q <= 1'b0;
      rd_pend_last_q <= 1'b0;
      fifo_cnt_q     <= 2'd0;
      q0             <= '0;
      q1             <= '0;
    end else begin
      rd_state_q     <= rd_state_d;
      rd_bank_q      <= rd_bank_d;
      rd_cnt_q       <= rd_cnt_d;
      rd_pend_q      <= rd_issue;
      rd_pend_user_q <= (rd_cnt_q == '0);
      rd_pend_last_q <= (rd_cnt_q == CW'(NOUT - 1));
      case ({push, pop})
        2'b10: begin
          if (fifo_cnt_q == 2'd0) q0 <= push_beat;
          else                    q1 <= push_beat;
          fifo_cnt_q <= fifo_cnt_q + 2'd1;
        end
        2'b01: begin
          q0         <= q1;
          fifo_cnt_q <= fifo_cnt_q - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt_q == 2'd1) begin
            q0 <= push_beat;
          end else begin
            q0 <= q1;
            q1 <= push_beat;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_axis.tvalid = (fifo_cnt_q != 2'd0);
  assign m_axis.tdata  = q0.data;
  assign m_axis.tuser  = m_axis.tvalid && q0.user;
  assign m_axis.tlast  = m_axis.tvalid && q0.last;
  assign o_drop_count  = drop_q;
  assign o_resync      = resync_q;

endmodule

// File: tb/tb_fft_csi_capture.sv
// Directed bench for fft_csi_capture: single frame with latency, back-to-back
// frames, random backpressure, overflow, resync and reset mid-stream.
module tb_fft_csi_capture;

  localparam int WIDTH  = 16;
  localparam int LGSIZE = 6;
  localparam int NUSED  = 26;
  localparam int N      = 1 << LGSIZE;
  localparam int NOUT   = 2 * NUSED;
  localparam int LIMIT  = 4000;

  logic               clk;
  logic               i_reset;
  logic               i_ce;
  logic               i_sync;
  logic [2*WIDTH-1:0] i_result;
  logic [15:0]        o_drop_count;
  logic               o_resync;

  fft_csi_capture_if #(.WIDTH(WIDTH)) axis ();

  fft_csi_capture #(.WIDTH(WIDTH), .LGSIZE(LGSIZE), .NUSED(NUSED)) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_ce         (i_ce),
    .i_sync       (i_sync),
    .i_result     (i_result),
    .m_axis       (axis),
    .o_drop_count (o_drop_count),
    .o_resync     (o_resync)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  // Accepted beats {tuser, tlast, tdata}, stall-stability violations, resync pulses
  logic [33:0] got [$];
  int          stall_viol = 0;
  int          resync_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [33:0] prev_beat  = '0;

  // Bank-occupancy model
  logic [1:0] m_full;
  logic       m_wr, m_rd, m_cap;
  int         m_acc, m_drop;
  int         exp_tags [$];
  int         base;
  logic       rand_ready;

  // Monitor, sampled on the falling edge away from the active edge
  always @(negedge clk) begin
    if (i_reset) begin
      prev_stall <= 1'b0;
    end else begin
      if (axis.tvalid && axis.tready) got.push_back({axis.tuser, axis.tlast, axis.tdata});
      if (prev_stall && (!axis.tvalid || ({axis.tuser, axis.tlast, axis.tdata} != prev_beat)))
        stall_viol <= stall_viol + 1;
      prev_stall <= axis.tvalid && !axis.tready;
      prev_beat  <= {axis.tuser, axis.tlast, axis.tdata};
    end
    if (o_resync) resync_cnt <= resync_cnt + 1;
  end

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp_v, input string tag);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] bin_val(input int tag, input int k);
    logic [15:0] re, im;
    re = 16'(tag * 256 + k);
    im = 16'(-k);
    return {re, im};
  endfunction

  function automatic logic [33:0] exp_beat(input int tag, input int j);
    int   bin;
    logic u, l;
    bin = (j < NUSED) ? (N - NUSED + j) : (j - NUSED + 1);
    u = (j == 0);
    l = (j == NOUT - 1);
    return {u, l, bin_val(tag, bin)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sets tready for the coming edge and retires a bank after every NOUT accepts
  task automatic model_pre();
    if (rand_ready) axis.tready = ($urandom_range(0, 99) < 30);
    if (!i_reset && axis.tvalid && axis.tready) begin
      m_acc++;
      if (m_acc % NOUT == 0) begin
        m_full[m_rd] = 1'b0;
        m_rd = ~m_rd;
      end
    end
  endtask

  task automatic step();
    model_pre();
    tick();
  endtask

  task automatic send_bin(input int tag, input int k);
    model_pre();
    i_ce     = 1'b1;
    i_sync   = (k == 0);
    i_result = bin_val(tag, k);
    if (k == 0) begin
      if (!m_full[m_wr]) m_cap = 1'b1;
      else begin
        m_cap = 1'b0;
        m_drop++;
      end
    end
    if ((k == N - 1) && m_cap) begin
      m_full[m_wr] = 1'b1;
      exp_tags.push_back(tag);
      m_wr = ~m_wr;
    end
    tick();
  endtask

  task automatic send_frame(input int tag, input int nbins);
    for (int k = 0; k < nbins; k++) send_bin(tag, k);
    i_ce   = 1'b0;
    i_sync = 1'b0;
  endtask

  task automatic model_reset();
    m_full = 2'b00;
    m_wr   = 1'b0;
    m_rd   = 1'b0;
    m_cap  = 1'b0;
    m_acc  = 0;
    m_drop = 0;
    exp_tags.delete();
    base = got.size();
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    i_ce    = 1'b0;
    i_sync  = 1'b0;
    tick();
    tick();
    i_reset = 1'b0;
    model_reset();
  endtask

  task automatic drain(input string name);
    int cyc;
    cyc = 0;
    while ((got.size() - base < exp_tags.size() * NOUT) && (cyc < LIMIT)) begin
      step();
      cyc++;
    end
    chk(64'(cyc < LIMIT), 64'(1), {name, "_timeout"});
    repeat (8) step();
  endtask

  task automatic check_frames(input string name);
    int idx;
    chk(64'(got.size() - base), 64'(exp_tags.size() * NOUT), {name, "_beats"});
    for (int f = 0; f < exp_tags.size(); f++) begin
      for (int j = 0; j < NOUT; j++) begin
        idx = base + f * NOUT + j;
        if (idx < got.size())
          chk(64'(got[idx]), 64'(exp_beat(exp_tags[f], j)), $sformatf("%s_f%0d_b%0d", name, f, j));
      end
    end
  endtask

  initial begin
    int r0;
    i_reset     = 1'b1;
    i_ce        = 1'b0;
    i_sync      = 1'b0;
    i_result    = '0;
    axis.tready = 1'b1;
    rand_ready  = 1'b0;
    model_reset();

    // Reset state
    do_reset();
    @(negedge clk);
    chk(64'(axis.tvalid), 64'(0), "rst_tvalid");
    chk(64'(axis.tuser), 64'(0), "rst_tuser");
    chk(64'(axis.tlast), 64'(0), "rst_tlast");
    chk(64'(o_drop_count), 64'(0), "rst_drop");
    chk(64'(o_resync), 64'(0), "rst_resync");
    tick();

    // Single frame, bin k = {k, -k}; first beat three cycles after bin 63
    send_frame(0, N);
    @(negedge clk);
    chk(64'(axis.tvalid), 64'(0), "lat_cyc1");
    @(negedge clk);
    chk(64'(axis.tvalid), 64'(0), "lat_cyc2");
    @(negedge clk);
    chk(64'(axis.tvalid), 64'(1), "lat_cyc3_valid");
    chk(64'(axis.tdata), 64'(32'h0026_FFDA), "lat_cyc3_data");
    chk(64'(axis.tuser), 64'(1), "lat_cyc3_tuser");
    drain("single");
    check_frames("single");

    // Ten back-to-back frames
    do_reset();
    for (int t = 1; t <= 10; t++) send_frame(t, N);
    drain("b2b");
    check_frames("b2b");
    chk(64'(exp_tags.size()), 64'(10), "b2b_frames");
    chk(64'(o_drop_count), 64'(0), "b2b_drop");

    // Random backpressure over four continuous frames
    do_reset();
    rand_ready = 1'b1;
    for (int t = 11; t <= 14; t++) send_frame(t, N);
    drain("bp");
    rand_ready  = 1'b0;
    axis.tready = 1'b1;
    check_frames("bp");
    chk(64'(o_drop_count), 64'(m_drop), "bp_drop");
    chk(64'(stall_viol), 64'(0), "bp_stall_stable");

    // Overflow: three frames with the sink stalled
    do_reset();
    axis.tready = 1'b0;
    for (int t = 21; t <= 23; t++) send_frame(t, N);
    chk(64'(o_drop_count), 64'(1), "ovf_drop");
    axis.tready = 1'b1;
    drain("ovf");
    check_frames("ovf");
    chk(64'(exp_tags.size()), 64'(2), "ovf_frames");

    // Resync at index 20 of a capture
    do_reset();
    r0 = resync_cnt;
    send_frame(30, 20);
    send_frame(31, N);
    drain("rsy");
    check_frames("rsy");
    chk(64'(resync_cnt - r0), 64'(1), "rsy_pulses");
    chk(64'(exp_tags.size() == 1 && exp_tags[0] == 31), 64'(1), "rsy_model");

    // Reset while output beat 10 is on the bus
    do_reset();
    send_frame(40, N);
    begin
      int cyc;
      cyc = 0;
      while ((got.size() - base < 10) && (cyc < LIMIT)) begin
        step();
        cyc++;
      end
      chk(64'(got.size() - base), 64'(10), "rstm_reach_beat10");
    end
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    model_reset();
    @(negedge clk);
    chk(64'(axis.tvalid), 64'(0), "rstm_tvalid");
    chk(64'(o_drop_count), 64'(0), "rstm_drop");
    tick();
    send_frame(41, N);
    drain("rstm");
    check_frames("rstm");
    chk(64'(stall_viol), 64'(0), "final_stall_stable");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
